// File: rtl/usb_phy_pkg.sv
// Line-state codes and link FSM states shared by the USB device link blocks.
// Thresholds are in clock cycles so simulation can run with scaled values.
package usb_phy_pkg;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        BUS_RESET = 3'd1,
        CHIRP_DET = 3'd2,
        HS_ACTIVE = 3'd3,
        SUSPEND   = 3'd4,
        RESUME    = 3'd5
    } link_state_e;

    function automatic int thr_max(input int a, input int b,
                                   input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/line_run_counter.sv
// Registers the previous line state and counts how long the current state
// has persisted, saturating so a threshold match can only fire once per run.
module line_run_counter
    import usb_phy_pkg::*;
#(
    parameter int W    = 5,
    parameter int MAXV = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   ls_i,
    output logic [1:0]   r_ls_o,
    output logic [W-1:0] run_cnt_o,
    output logic         changed_o
);

    localparam logic [W-1:0] SAT = W'(MAXV);
    localparam logic [W-1:0] ONE = W'(1);

    logic [1:0]   r_ls_q;
    logic [W-1:0] run_cnt_q;
    logic [W-1:0] run_cnt_d;

    assign changed_o = (ls_i != r_ls_q);
    assign r_ls_o    = r_ls_q;
    assign run_cnt_o = run_cnt_q;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (changed_o) begin
            run_cnt_d = ONE;
        end else if (run_cnt_q != SAT) begin
            run_cnt_d = run_cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ls_q    <= LS_SE0;
            run_cnt_q <= '0;
        end else begin
            r_ls_q    <= ls_i;
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule

// File: rtl/usb_link_state_ctrl.sv
// Device-side link sequencer: bus reset, suspend/resume and HS chirp
// detection from the registered PHY line state; drives the HS select.
module usb_link_state_ctrl
    import usb_phy_pkg::*;
#(
    parameter int RST_CYC     = 8,
    parameter int SUSP_CYC    = 12,
    parameter int RES_CYC     = 6,
    parameter int CHIRP_CYC   = 4,
    parameter int CHIRP_PAIRS = 3,
    parameter int CHIRP_TMO   = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_line_state,
    input  logic       i_hs_capable,
    output logic       o_hs_mode,
    output logic [2:0] o_state,
    output logic       o_bus_reset,
    output logic       o_suspend,
    output logic       o_resume,
    output logic       o_hs_grant,
    output logic       o_se1_err
);

    localparam int MAXT = thr_max(RST_CYC, SUSP_CYC, RES_CYC, CHIRP_CYC);
    localparam int CW   = $clog2(MAXT) + 1;
    localparam int PW   = $clog2(CHIRP_PAIRS) + 1;
    localparam int TW   = $clog2(CHIRP_TMO) + 1;

    localparam logic [CW-1:0] RST_M1   = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] SUSP_M1  = CW'(SUSP_CYC - 1);
    localparam logic [CW-1:0] RES_M1   = CW'(RES_CYC - 1);
    localparam logic [CW-1:0] CHIRP_M1 = CW'(CHIRP_CYC - 1);
    localparam logic [PW-1:0] PAIR_M1  = PW'(CHIRP_PAIRS - 1);
    localparam logic [TW-1:0] TMO_M1   = TW'(CHIRP_TMO - 1);

    logic [1:0]    r_ls;
    logic [CW-1:0] run_cnt;
    logic          ls_changed;

    line_run_counter #(
        .W    (CW),
        .MAXV (MAXT)
    ) u_run (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .ls_i      (i_line_state),
        .r_ls_o    (r_ls),
        .run_cnt_o (run_cnt),
        .changed_o (ls_changed)
    );

    link_state_e   state_q, state_d;
    logic [PW-1:0] pair_q, pair_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          expj_q, expj_d;
    logic          segok_q, segok_d;
    logic          hs_prev_q, hs_prev_d;

    logic          hs_mode_q, bus_reset_q, suspend_q;
    logic          resume_q, hs_grant_q, se1_err_q;

    logic          rst_ev, susp_ev, res_ev, seg_ev, se1_edge;
    logic [1:0]    exp_ls;

    assign exp_ls   = expj_q ? LS_J : LS_K;
    assign rst_ev   = (i_line_state == LS_SE0) && (r_ls == LS_SE0)
                      && (run_cnt == RST_M1);
    assign susp_ev  = (i_line_state == LS_J) && (r_ls == LS_J)
                      && (run_cnt == SUSP_M1);
    assign res_ev   = (i_line_state == LS_K) && (r_ls == LS_K)
                      && (run_cnt == RES_M1);
    assign seg_ev   = (i_line_state == exp_ls) && (r_ls == exp_ls)
                      && (run_cnt == CHIRP_M1);
    assign se1_edge = (i_line_state == LS_SE1) && (r_ls != LS_SE1);

    always_comb begin
        state_d   = state_q;
        pair_d    = pair_q;
        tmo_d     = tmo_q;
        expj_d    = expj_q;
        segok_d   = segok_q;
        hs_prev_d = hs_prev_q;
        if ((state_q != BUS_RESET) && rst_ev) begin
            state_d = BUS_RESET;
        end else begin
            unique case (state_q)
                FS_IDLE: begin
                    if (susp_ev) begin
                        state_d   = SUSPEND;
                        hs_prev_d = 1'b0;
                    end
                end
                BUS_RESET: begin
                    if (i_line_state != LS_SE0) begin
                        if (i_hs_capable) begin
                            state_d = CHIRP_DET;
                            pair_d  = '0;
                            tmo_d   = '0;
                            expj_d  = 1'b0;
                            segok_d = 1'b0;
                        end else begin
                            state_d = FS_IDLE;
                        end
                    end
                end
                CHIRP_DET: begin
                    tmo_d = tmo_q + 1'b1;
                    if (i_line_state == LS_SE1) begin
                        state_d = FS_IDLE;
                    end else if (tmo_q == TMO_M1) begin
                        state_d = FS_IDLE;
                    end else begin
                        // SE0 glitches are left to the bus-reset rule
                        if (ls_changed && (i_line_state != LS_SE0)) begin
                            segok_d = 1'b0;
                            if (!segok_q) begin
                                pair_d = '0;
                                expj_d = 1'b0;
                            end
                        end
                        if (seg_ev) begin
                            segok_d = 1'b1;
                            expj_d  = !expj_q;
                            if (expj_q) begin
                                pair_d = pair_q + 1'b1;
                                if (pair_q == PAIR_M1) begin
                                    state_d = HS_ACTIVE;
                                end
                            end
                        end
                    end
                end
                HS_ACTIVE: begin
                    state_d = HS_ACTIVE;
                end
                SUSPEND: begin
                    if (res_ev) begin
                        state_d = RESUME;
                    end
                end
                RESUME: begin
                    if ((i_line_state == LS_SE0) || (i_line_state == LS_J)) begin
                        state_d = hs_prev_q ? HS_ACTIVE : FS_IDLE;
                    end
                end
                default: begin
                    state_d = FS_IDLE;
                end
            endcase
        end
        if ((state_d == HS_ACTIVE) && (state_q != HS_ACTIVE)) begin
            hs_prev_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= FS_IDLE;
            pair_q      <= '0;
            tmo_q       <= '0;
            expj_q      <= 1'b0;
            segok_q     <= 1'b0;
            hs_prev_q   <= 1'b0;
            hs_mode_q   <= 1'b0;
            bus_reset_q <= 1'b0;
            suspend_q   <= 1'b0;
            resume_q    <= 1'b0;
            hs_grant_q  <= 1'b0;
            se1_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pair_q      <= pair_d;
            tmo_q       <= tmo_d;
            expj_q      <= expj_d;
            segok_q     <= segok_d;
            hs_prev_q   <= hs_prev_d;
            hs_mode_q   <= (state_d == HS_ACTIVE);
            bus_reset_q <= (state_d == BUS_RESET) && (state_q != BUS_RESET);
            suspend_q   <= (state_d == SUSPEND);
            resume_q    <= (state_d == RESUME) && (state_q != RESUME);
            hs_grant_q  <= (state_d == HS_ACTIVE) && (state_q != HS_ACTIVE);
            se1_err_q   <= se1_edge;
        end
    end

    assign o_state     = state_q;
    assign o_hs_mode   = hs_mode_q;
    assign o_bus_reset = bus_reset_q;
    assign o_suspend   = suspend_q;
    assign o_resume    = resume_q;
    assign o_hs_grant  = hs_grant_q;
    assign o_se1_err   = se1_err_q;

endmodule

// File: tb/tb_usb_link_state_ctrl.sv
// Scoreboard bench for usb_link_state_ctrl: directed link scenarios
// followed by randomized line traffic against a behavioural model.
module tb_usb_link_state_ctrl;
    import usb_phy_pkg::*;

    localparam int RST_CYC     = 8;
    localparam int SUSP_CYC    = 12;
    localparam int RES_CYC     = 6;
    localparam int CHIRP_CYC   = 4;
    localparam int CHIRP_PAIRS = 3;
    localparam int CHIRP_TMO   = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ls    = LS_SE0;
    logic       cap   = 1'b0;
    logic       hs_mode, bus_reset, suspend, resume, hs_grant, se1_err;
    logic [2:0] state;

    always #5 clk = ~clk;

    usb_link_state_ctrl #(
        .RST_CYC     (RST_CYC),
        .SUSP_CYC    (SUSP_CYC),
        .RES_CYC     (RES_CYC),
        .CHIRP_CYC   (CHIRP_CYC),
        .CHIRP_PAIRS (CHIRP_PAIRS),
        .CHIRP_TMO   (CHIRP_TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_line_state (ls),
        .i_hs_capable (cap),
        .o_hs_mode    (hs_mode),
        .o_state      (state),
        .o_bus_reset  (bus_reset),
        .o_suspend    (suspend),
        .o_resume     (resume),
        .o_hs_grant   (hs_grant),
        .o_se1_err    (se1_err)
    );

    typedef logic [8:0] obs_t;
    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int checks = 0, failures = 0;
    int n_br = 0, n_res = 0, n_grant = 0, n_se1 = 0;

    // Reference model: line history as a plain run length, chirp progress
    // as a pair count and the segment kind wanted next.
    link_state_e m_st;
    logic [1:0]  m_prev, m_want;
    int          m_run, m_pairs, m_tmo;
    bit          m_segok, m_hsprev;

    function automatic obs_t dut_obs();
        return {hs_mode, state, bus_reset, suspend, resume, hs_grant, se1_err};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = FS_IDLE; m_prev = LS_SE0; m_want = LS_K;
        m_run = 0; m_pairs = 0; m_tmo = 0; m_segok = 0; m_hsprev = 0;
    endtask

    task automatic model_step(input logic [1:0] l);
        link_state_e nxt;
        bit se1p, chg;
        se1p   = (l == LS_SE1) && (m_prev != LS_SE1);
        chg    = (l != m_prev);
        m_run  = chg ? 1 : m_run + 1;
        m_prev = l;
        nxt    = m_st;
        if (l == LS_SE0 && m_run == RST_CYC && m_st != BUS_RESET) begin
            nxt = BUS_RESET;
        end else begin
            case (m_st)
                FS_IDLE: if (l == LS_J && m_run == SUSP_CYC) begin
                    nxt = SUSPEND; m_hsprev = 0;
                end
                BUS_RESET: if (l != LS_SE0) begin
                    if (cap) begin
                        nxt = CHIRP_DET; m_pairs = 0; m_want = LS_K;
                        m_tmo = 0; m_segok = 0;
                    end else nxt = FS_IDLE;
                end
                CHIRP_DET: begin
                    m_tmo++;
                    if (l == LS_SE1) nxt = FS_IDLE;
                    else if (m_tmo == CHIRP_TMO) nxt = FS_IDLE;
                    else begin
                        if (chg && l != LS_SE0) begin
                            if (!m_segok) begin m_pairs = 0; m_want = LS_K; end
                            m_segok = 0;
                        end
                        if (l == m_want && m_run == CHIRP_CYC) begin
                            m_segok = 1;
                            if (m_want == LS_J) begin
                                m_pairs++; m_want = LS_K;
                                if (m_pairs == CHIRP_PAIRS) nxt = HS_ACTIVE;
                            end else m_want = LS_J;
                        end
                    end
                end
                SUSPEND: if (l == LS_K && m_run == RES_CYC) nxt = RESUME;
                RESUME: if (l == LS_SE0 || l == LS_J)
                    nxt = m_hsprev ? HS_ACTIVE : FS_IDLE;
                default: ;
            endcase
        end
        if (nxt == HS_ACTIVE && m_st != HS_ACTIVE) m_hsprev = 1;
        exp_q.push_back({nxt == HS_ACTIVE, nxt,
                         nxt == BUS_RESET && m_st != BUS_RESET,
                         nxt == SUSPEND,
                         nxt == RESUME && m_st != RESUME,
                         nxt == HS_ACTIVE && m_st != HS_ACTIVE,
                         se1p});
        m_st = nxt;
    endtask

    always @(posedge clk) begin
        #1;
        n_br    += int'(bus_reset);
        n_res   += int'(resume);
        n_grant += int'(hs_grant);
        n_se1   += int'(se1_err);
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = dut_obs();
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL scoreboard t=%0t act=%b exp=%b", $time, mon_a, mon_e);
            end
        end
    end

    task automatic step(input logic [1:0] l);
        @(negedge clk);
        ls = l;
        model_step(l);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input logic [1:0] l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_outs_zero"}, int'(dut_obs()), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk({tag, "_idle_after"}, int'(state), int'(FS_IDLE));
    endtask

    initial begin
        int b, mode, len, np;
        logic [1:0] l;
        model_reset();
        #1;
        chk("reset_outs_zero", int'(dut_obs()), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        cap = 1'b0;
        b = n_br;
        run(LS_SE0, 10);
        run(LS_J, 2);
        chk("fs_reset_pulses", n_br - b, 1);
        chk("fs_state", int'(state), int'(FS_IDLE));
        chk("fs_hs_mode", int'(hs_mode), 0);

        cap = 1'b1;
        run(LS_SE0, 8);
        chk("hs_enter_reset", int'(state), int'(BUS_RESET));
        b = n_grant;
        for (int p = 0; p < CHIRP_PAIRS; p++) begin
            run(LS_K, 4);
            run(LS_J, 4);
        end
        chk("hs_grant_pulses", n_grant - b, 1);
        chk("hs_mode_on", int'(hs_mode), 1);
        chk("hs_state", int'(state), int'(HS_ACTIVE));

        b = n_br;
        run(LS_SE0, 8);
        chk("hs_reset_pulse", n_br - b, 1);
        chk("hs_reset_mode_off", int'(hs_mode), 0);
        chk("hs_reset_state", int'(state), int'(BUS_RESET));

        b = n_grant;
        run(LS_K, 4); run(LS_J, 2);
        run(LS_K, 4); run(LS_J, 4);
        run(LS_K, 4); run(LS_J, 4);
        chk("chirp_restart_no_grant", n_grant - b, 0);
        chk("chirp_restart_state", int'(state), int'(CHIRP_DET));
        run(LS_K, 4); run(LS_J, 4);
        chk("chirp_restart_grant", n_grant - b, 1);
        chk("chirp_restart_hs", int'(state), int'(HS_ACTIVE));

        run(LS_SE0, 8);
        b = n_grant;
        run(LS_K, 70);
        chk("chirp_tmo_state", int'(state), int'(FS_IDLE));
        chk("chirp_tmo_hs_off", int'(hs_mode), 0);
        chk("chirp_tmo_no_grant", n_grant - b, 0);

        run(LS_J, 12);
        chk("susp_level", int'(suspend), 1);
        chk("susp_state", int'(state), int'(SUSPEND));
        b = n_res;
        run(LS_K, 6);
        chk("resume_pulse", n_res - b, 1);
        chk("resume_susp_off", int'(suspend), 0);
        step(LS_SE0);
        chk("resume_to_fs", int'(state), int'(FS_IDLE));
        b = n_br;
        run(LS_SE0, 7);
        chk("resume_then_reset", n_br - b, 1);

        cap = 1'b0;
        run(LS_J, 12);
        chk("susp2_level", int'(suspend), 1);
        b = n_br;
        run(LS_SE0, 8);
        chk("susp_reset_pulse", n_br - b, 1);
        chk("susp_reset_off", int'(suspend), 0);
        chk("susp_reset_state", int'(state), int'(BUS_RESET));

        run(LS_J, 2);
        b = n_se1;
        run(LS_SE1, 3);
        chk("se1_one_pulse", n_se1 - b, 1);
        chk("se1_keeps_state", int'(state), int'(FS_IDLE));
        run(LS_J, 2);

        cap = 1'b1;
        run(LS_SE0, 8);
        run(LS_K, 5);
        chk("pre_async_chirp", int'(state), int'(CHIRP_DET));
        async_reset("async_chirp");
        step(LS_J);
        chk("post_async_state", int'(state), int'(FS_IDLE));

        for (int it = 0; it < 300; it++) begin
            mode = $urandom_range(0, 19);
            if (mode <= 3) begin
                run(LS_SE0, $urandom_range(1, 12));
            end else if (mode == 4) begin
                run(LS_SE1, $urandom_range(1, 3));
            end else if (mode <= 9) begin
                l = ($urandom_range(0, 1) != 0) ? LS_K : LS_J;
                run(l, $urandom_range(1, 16));
            end else if (mode <= 15) begin
                if ($urandom_range(0, 1) != 0) run(LS_SE0, 8);
                np = $urandom_range(1, 4);
                for (int p = 0; p < np; p++) begin
                    run(LS_K, $urandom_range(3, 6));
                    run(LS_J, $urandom_range(3, 6));
                end
            end else if (mode <= 17) begin
                run(LS_J, $urandom_range(10, 14));
                run(LS_K, $urandom_range(4, 8));
            end else if (mode == 18) begin
                cap = ($urandom_range(0, 1) != 0);
            end else begin
                len = $urandom_range(0, 3);
                if (len == 0) async_reset("async_rand");
                else step(LS_J);
            end
        end

        run(LS_J, 2);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
